// File: rtl/clb_switch_box_multictx_if.sv
// Bundle for the multi-context switch box: config chain, bank control, fabric.
// master drives config and *_in wires; slave is the switch box itself.
interface clb_switch_box_multictx_if #(
    parameter int WS   = 4,
    parameter int WD   = 8,
    parameter int NCTX = 2
);
    localparam int CW = (NCTX > 1) ? $clog2(NCTX) : 1;

    logic            cen;
    logic            shift_in;
    logic            shift_out;
    logic            set_in;
    logic [CW-1:0]   wr_ctx;
    logic            swap_req;
    logic [CW-1:0]   swap_ctx;
    logic [CW-1:0]   active_ctx;
    logic            live_valid;
    logic [NCTX-1:0] ctx_valid;
    logic            cfg_err;

    logic [WS-1:0] north_single_in, east_single_in;
    logic [WS-1:0] south_single_in, west_single_in;
    logic [WS-1:0] north_single_out, east_single_out;
    logic [WS-1:0] south_single_out, west_single_out;
    logic [WD-1:0] north_double_in, east_double_in;
    logic [WD-1:0] south_double_in, west_double_in;
    logic [WD-1:0] north_double_out, east_double_out;
    logic [WD-1:0] south_double_out, west_double_out;

    modport master (
        output cen, shift_in, set_in, wr_ctx, swap_req, swap_ctx,
        output north_single_in, east_single_in,
        output south_single_in, west_single_in,
        output north_double_in, east_double_in,
        output south_double_in, west_double_in,
        input  shift_out, active_ctx, live_valid, ctx_valid, cfg_err,
        input  north_single_out, east_single_out,
        input  south_single_out, west_single_out,
        input  north_double_out, east_double_out,
        input  south_double_out, west_double_out
    );

    modport slave (
        input  cen, shift_in, set_in, wr_ctx, swap_req, swap_ctx,
        input  north_single_in, east_single_in,
        input  south_single_in, west_single_in,
        input  north_double_in, east_double_in,
        input  south_double_in, west_double_in,
        output shift_out, active_ctx, live_valid, ctx_valid, cfg_err,
        output north_single_out, east_single_out,
        output south_single_out, west_single_out,
        output north_double_out, east_double_out,
        output south_double_out, west_double_out
    );
endinterface

// File: rtl/clb_switch_box_multictx.sv
// Multi-context unidirectional CLB switch box: NCTX banks behind one shift
// chain, atomic swap into a live register that drives the routing muxes.
// Ports: clk, rst (async high), bus (slave modport: config chain, set/swap
// control, status, and N/E/S/W single and double wire bundles).
//
// Config layout (2-bit select per output, 0 = off, k = side (s+k)%4,
// sides N=0 E=1 S=2 W=3):
//   single track i, side s : conf[(i*4+s)*2 +: 2]
//   double pair j,  side s : conf[WS*8+(j*4+s)*2 +: 2]
// A double pair is staggered: out[2j] takes in[2j+1] and out[2j+1] takes
// in[2j] from the selected side.
module clb_switch_box_multictx #(
    parameter int WS   = 4,
    parameter int WD   = 8,
    parameter int NCTX = 2
) (
    input logic clk,
    input logic rst,
    clb_switch_box_multictx_if.slave bus
);
    localparam int CONF_W = (WS + WD / 2) * 8;
    localparam int CW     = (NCTX > 1) ? $clog2(NCTX) : 1;
    localparam int BW     = $clog2(CONF_W + 2);
    localparam int ND     = WD / 2;

    localparam logic [BW-1:0] CNT_FULL = BW'(CONF_W);
    localparam logic [BW-1:0] CNT_SAT  = BW'(CONF_W + 1);

    logic [CONF_W-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic [CONF_W-1:0] bank [NCTX];
    logic [NCTX-1:0]   ctx_valid;
    logic [CONF_W-1:0] live_conf;
    logic [CW-1:0]     active_ctx;
    logic              live_valid;
    logic              cfg_err;

    logic wr_ok, set_fail, swap_ok, swap_fail;

    assign wr_ok = bus.set_in && (bit_cnt == CNT_FULL)
                && (32'(bus.wr_ctx) < NCTX);
    assign set_fail = bus.set_in && !wr_ok;

    // Swap looks at pre-edge bank contents and validity, so a same-cycle
    // set to the same index is not visible until the next swap.
    assign swap_ok = bus.swap_req && (32'(bus.swap_ctx) < NCTX)
                  && ctx_valid[bus.swap_ctx];
    assign swap_fail = bus.swap_req && !swap_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            ctx_valid  <= '0;
            live_conf  <= '0;
            active_ctx <= '0;
            live_valid <= 1'b0;
            cfg_err    <= 1'b0;
            for (int k = 0; k < NCTX; k++) begin
                bank[k] <= '0;
            end
        end else begin
            if (bus.set_in) begin
                bit_cnt <= '0;
                if (wr_ok) begin
                    bank[bus.wr_ctx]      <= shreg;
                    ctx_valid[bus.wr_ctx] <= 1'b1;
                end
            end else if (bus.cen) begin
                shreg <= {shreg[CONF_W-2:0], bus.shift_in};
                if (bit_cnt != CNT_SAT) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (swap_ok) begin
                live_conf  <= bank[bus.swap_ctx];
                active_ctx <= bus.swap_ctx;
                live_valid <= 1'b1;
            end

            // A lone successful swap leaves the flag alone.
            if (bus.set_in || swap_fail) begin
                cfg_err <= set_fail || swap_fail;
            end
        end
    end

    assign bus.shift_out  = shreg[CONF_W-1];
    assign bus.active_ctx = active_ctx;
    assign bus.live_valid = live_valid;
    assign bus.ctx_valid  = ctx_valid;
    assign bus.cfg_err    = cfg_err;

    logic [3:0][WS-1:0] s_in, s_out;
    logic [3:0][WD-1:0] d_in, d_out;

    assign s_in = {bus.west_single_in, bus.south_single_in,
                   bus.east_single_in, bus.north_single_in};
    assign d_in = {bus.west_double_in, bus.south_double_in,
                   bus.east_double_in, bus.north_double_in};

    for (genvar s = 0; s < 4; s++) begin : g_side
        for (genvar i = 0; i < WS; i++) begin : g_single
            logic [1:0] sel, src;
            logic       en;
            assign sel = live_conf[(i*4+s)*2 +: 2];
            assign src = 2'(s) + sel;
            assign en  = live_valid && (sel != 2'd0);
            assign s_out[s][i] = en && s_in[src][i];
        end
        for (genvar j = 0; j < ND; j++) begin : g_double
            logic [1:0] sel, src;
            logic       en;
            assign sel = live_conf[WS*8+(j*4+s)*2 +: 2];
            assign src = 2'(s) + sel;
            assign en  = live_valid && (sel != 2'd0);
            assign d_out[s][2*j]   = en && d_in[src][2*j+1];
            assign d_out[s][2*j+1] = en && d_in[src][2*j];
        end
    end

    assign bus.north_single_out = s_out[0];
    assign bus.east_single_out  = s_out[1];
    assign bus.south_single_out = s_out[2];
    assign bus.west_single_out  = s_out[3];
    assign bus.north_double_out = d_out[0];
    assign bus.east_double_out  = d_out[1];
    assign bus.south_double_out = d_out[2];
    assign bus.west_double_out  = d_out[3];
endmodule

// File: tb/tb_clb_switch_box_multictx.sv
// Self-checking bench for clb_switch_box_multictx (WS=4, WD=8, NCTX=2).
// Expectations are queued with each stimulus and compared after the edge.
module tb_clb_switch_box_multictx;
    localparam int WS   = 4;
    localparam int WD   = 8;
    localparam int NCTX = 2;

    // A: west single 0 -> east single 0; B: north single 0 -> south single 0
    localparam logic [127:0] CONF_A = 128'h8;
    localparam logic [127:0] CONF_B = 128'h20;

    localparam int S_CV    = 0;
    localparam int S_LV    = 1;
    localparam int S_ERR   = 2;
    localparam int S_ACT   = 3;
    localparam int S_EAST  = 4;
    localparam int S_SOUTH = 5;
    localparam int S_SO    = 6;
    localparam int S_ANY   = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clb_switch_box_multictx_if #(.WS(WS), .WD(WD), .NCTX(NCTX)) bus ();

    clb_switch_box_multictx #(.WS(WS), .WD(WD), .NCTX(NCTX)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] sample(int sig);
        case (sig)
            S_CV:    return 32'(bus.ctx_valid);
            S_LV:    return 32'(bus.live_valid);
            S_ERR:   return 32'(bus.cfg_err);
            S_ACT:   return 32'(bus.active_ctx);
            S_EAST:  return 32'(bus.east_single_out);
            S_SOUTH: return 32'(bus.south_single_out);
            S_SO:    return 32'(bus.shift_out);
            default: return 32'(|{bus.north_single_out, bus.east_single_out,
                                  bus.south_single_out, bus.west_single_out,
                                  bus.north_double_out, bus.east_double_out,
                                  bus.south_double_out, bus.west_double_out});
        endcase
    endfunction

    task automatic push(string tag, int sig, logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, sample(e.sig), e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic settle();
        #1;
        drain();
    endtask

    task automatic shift_bits(logic [127:0] v, int n);
        for (int k = n - 1; k >= 0; k--) begin
            bus.shift_in = v[7'(k)];
            bus.cen      = 1'b1;
            step();
        end
        bus.cen      = 1'b0;
        bus.shift_in = 1'b0;
    endtask

    task automatic do_set(int ctx);
        bus.set_in = 1'b1;
        bus.wr_ctx = 1'(ctx);
        step();
        bus.set_in = 1'b0;
    endtask

    task automatic do_swap(int ctx);
        bus.swap_req = 1'b1;
        bus.swap_ctx = 1'(ctx);
        step();
        bus.swap_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.cen = 0; bus.shift_in = 0; bus.set_in = 0; bus.wr_ctx = 0;
        bus.swap_req = 0; bus.swap_ctx = 0;
        bus.north_single_in = 0; bus.east_single_in = 0;
        bus.south_single_in = 0; bus.west_single_in = 0;
        bus.north_double_in = 0; bus.east_double_in = 0;
        bus.south_double_in = 0; bus.west_double_in = 0;

        repeat (2) @(posedge clk);
        #1;
        push("rst_outs", S_ANY, 0);
        push("rst_so", S_SO, 0);
        settle();
        rst = 1'b0;
        push("rel_cv", S_CV, 0);
        push("rel_lv", S_LV, 0);
        push("rel_err", S_ERR, 0);
        step();

        push("inv_swap_lv", S_LV, 0);
        push("inv_swap_err", S_ERR, 1);
        push("inv_swap_outs", S_ANY, 0);
        do_swap(1);

        shift_bits(128'(1) << 62, 63);
        push("lat_63", S_SO, 0);
        settle();
        shift_bits(128'h0, 1);
        push("lat_64", S_SO, 1);
        settle();
        shift_bits(128'h0, 1);
        push("lat_65", S_SO, 0);
        settle();
        push("ovf_set_err", S_ERR, 1);
        push("ovf_set_cv", S_CV, 0);
        do_set(0);

        shift_bits(CONF_A, 64);
        push("setA_err", S_ERR, 0);
        push("setA_cv", S_CV, 1);
        do_set(0);
        push("swapA_lv", S_LV, 1);
        push("swapA_act", S_ACT, 0);
        do_swap(0);
        bus.west_single_in = 4'h1;
        push("A_w2e_hi", S_EAST, 1);
        settle();
        bus.west_single_in = 4'h0;
        push("A_w2e_lo", S_EAST, 0);
        settle();

        shift_bits(CONF_B, 63);
        push("b63_err", S_ERR, 1);
        push("b63_cv", S_CV, 1);
        do_set(0);
        push("b63_swap_lv", S_LV, 1);
        do_swap(0);
        bus.west_single_in  = 4'h1;
        bus.north_single_in = 4'h1;
        push("b63_keep_east", S_EAST, 1);
        push("b63_keep_south", S_SOUTH, 0);
        settle();
        bus.west_single_in  = 4'h0;
        bus.north_single_in = 4'h0;

        shift_bits(CONF_A, 65);
        push("a65_err", S_ERR, 1);
        do_set(0);

        shift_bits(CONF_A, 64);
        bus.set_in = 1'b1;
        bus.wr_ctx = 1'b0;
        push("held_set_1", S_ERR, 0);
        step();
        push("held_set_2", S_ERR, 1);
        step();
        bus.set_in = 1'b0;

        shift_bits(CONF_B, 64);
        push("bg_cv", S_CV, 3);
        push("bg_err", S_ERR, 0);
        do_set(1);
        bus.west_single_in  = 4'h1;
        bus.north_single_in = 4'h1;
        push("bg_live_east", S_EAST, 1);
        push("bg_live_south", S_SOUTH, 0);
        push("bg_live_act", S_ACT, 0);
        settle();
        push("swapB_act", S_ACT, 1);
        push("swapB_south", S_SOUTH, 1);
        push("swapB_east", S_EAST, 0);
        do_swap(1);
        bus.west_single_in  = 4'h0;
        bus.north_single_in = 4'h0;

        shift_bits(CONF_B, 64);
        bus.north_single_in = 4'h1;
        bus.set_in   = 1'b1;
        bus.wr_ctx   = 1'b0;
        bus.swap_req = 1'b1;
        bus.swap_ctx = 1'b0;
        push("simul_act", S_ACT, 0);
        push("simul_err", S_ERR, 0);
        push("simul_south", S_SOUTH, 0);
        step();
        bus.set_in   = 1'b0;
        bus.swap_req = 1'b0;
        bus.west_single_in = 4'h1;
        push("simul_oldA", S_EAST, 1);
        settle();
        bus.west_single_in = 4'h0;
        push("simul_2nd_south", S_SOUTH, 1);
        push("simul_2nd_east", S_EAST, 0);
        do_swap(0);

        @(posedge clk);
        #3;
        rst = 1'b1;
        push("async_outs", S_ANY, 0);
        push("async_lv", S_LV, 0);
        settle();
        bus.north_single_in = 4'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push("rst2_cv", S_CV, 0);
        push("rst2_act", S_ACT, 0);
        push("rst2_err", S_ERR, 0);
        settle();
        push("rst2_set_err", S_ERR, 1);
        push("rst2_set_cv", S_CV, 0);
        do_set(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
